nios_system_pio_in_edge: RTL and testbench



---
 rtl/nios_system_pio_in_edge_if.sv | 19 +
 rtl/nios_system_pio_in_edge.sv | 126 ++++++++++++
 tb/tb_nios_system_pio_in_edge.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_pio_in_edge_if.sv
// rtl/nios_system_pio_in_edge_if.sv - Avalon-MM register bus and irq for the edge-capture input PIO
interface nios_system_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_system_pio_in_edge.sv
// rtl/nios_system_pio_in_edge.sv - input PIO with synchroniser, edge capture, irq mask; NIOS_PIO_DEBOUNCE_EN adds per-bit debounce
module nios_system_pio_in_edge #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_port,
  nios_system_pio_in_edge_if.slave  s_bus
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_capture;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_sync_val;
  logic [WIDTH-1:0] w_val;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync_val = r_sync[SYNC_STAGES-1];

`ifdef NIOS_PIO_DEBOUNCE_EN
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_deb;

  // The increment that would reach DEBOUNCE_CYCLES flips deb instead.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_deb <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync_val[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_val = r_deb;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign w_val = w_sync_val;
`endif

  assign w_rise = w_val & ~r_prev;
  assign w_fall = ~w_val & r_prev;

  always_comb begin
    w_event = '0;
    case (EDGE_TYPE)
      0:       w_event = w_rise;
      1:       w_event = w_fall;
      default: w_event = w_rise | w_fall;
    endcase
  end

  assign w_wr  = s_bus.chipselect & ~s_bus.write_n;
  assign w_clr = (w_wr && s_bus.address == 2'd3) ? s_bus.writedata[WIDTH-1:0] : '0;

  // Set wins over a same-cycle clear so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_capture <= '0;
      r_mask    <= '0;
    end else begin
      r_prev    <= w_val;
      r_capture <= (r_capture & ~w_clr) | w_event;
      if (w_wr && s_bus.address == 2'd2) r_mask <= s_bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (s_bus.address)
      2'd0:    w_rd_mux[WIDTH-1:0] = w_val;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_capture;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd_mux;
  end

  generate
    if (WIDTH < 32) begin : g_wd_upper
      logic w_unused_wd;
      assign w_unused_wd = ^s_bus.writedata[31:WIDTH];
    end
  endgenerate

  assign s_bus.readdata = r_readdata;
  assign s_bus.irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// tb/tb_nios_system_pio_in_edge.sv - randomised model-checked bench for three edge types of the input PIO
module tb_nios_system_pio_in_edge;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int SETTLE = SYNC + DEB + 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_edge_if bus0 ();
  nios_system_pio_in_edge_if bus1 ();
  nios_system_pio_in_edge_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
  assign bus1.address = address;  assign bus1.chipselect = chipselect;
  assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
  assign bus2.address = address;  assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

  nios_system_pio_in_edge #(.WIDTH(16), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DEB))
    u_rise (.clk(clk), .reset_n(reset_n), .in_port(in_port), .s_bus(bus0));
  nios_system_pio_in_edge #(.WIDTH(16), .SYNC_STAGES(SYNC), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DEB))
    u_fall (.clk(clk), .reset_n(reset_n), .in_port(in_port), .s_bus(bus1));
  nios_system_pio_in_edge #(.WIDTH(16), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DEB))
    u_any  (.clk(clk), .reset_n(reset_n), .in_port(in_port), .s_bus(bus2));

  logic [31:0] d_rd  [3];
  logic        d_irq [3];
  assign d_rd[0] = bus0.readdata;  assign d_irq[0] = bus0.irq;
  assign d_rd[1] = bus1.readdata;  assign d_irq[1] = bus1.irq;
  assign d_rd[2] = bus2.readdata;  assign d_irq[2] = bus2.irq;

  // Reference model: the input is seen SYNC samples late, optionally filtered.
  logic [15:0] m_hist [SYNC];
  logic [15:0] m_deb;
  int          m_cnt  [16];
  logic [15:0] m_prev;
  logic [15:0] m_cap  [3];
  logic [15:0] m_mask;
  logic [31:0] m_rd   [3];

  function automatic logic [15:0] m_vis();
`ifdef NIOS_PIO_DEBOUNCE_EN
    return m_deb;
`else
    return m_hist[SYNC-1];
`endif
  endfunction

  function automatic logic m_irq(input int t);
    return |(m_cap[t] & m_mask);
  endfunction

  task automatic tick();
    logic [15:0] n_hist [SYNC];
    logic [15:0] n_cap  [3];
    logic [31:0] n_rd   [3];
    int          n_cnt  [16];
    logic [15:0] n_deb, n_prev, n_mask, cur, rise, fall, clr, last;
    logic        wr;
    if (!reset_n) begin
      for (int i = 0; i < SYNC; i++) n_hist[i] = '0;
      for (int b = 0; b < 16; b++) n_cnt[b] = 0;
      for (int t = 0; t < 3; t++) begin n_cap[t] = '0; n_rd[t] = '0; end
      n_deb = '0; n_prev = '0; n_mask = '0;
    end else begin
      n_hist[0] = in_port;
      for (int i = 1; i < SYNC; i++) n_hist[i] = m_hist[i-1];
      cur   = m_vis();
      last  = m_hist[SYNC-1];
      n_deb = m_deb;
      n_cnt = m_cnt;
`ifdef NIOS_PIO_DEBOUNCE_EN
      for (int b = 0; b < 16; b++) begin
        if (last[b] == m_deb[b]) n_cnt[b] = 0;
        else if (m_cnt[b] + 1 == DEB) begin n_deb[b] = ~m_deb[b]; n_cnt[b] = 0; end
        else n_cnt[b] = m_cnt[b] + 1;
      end
`endif
      rise   = cur & ~m_prev;
      fall   = ~cur & m_prev;
      wr     = chipselect && !write_n;
      clr    = (wr && address == 2'd3) ? writedata[15:0] : 16'h0;
      n_cap[0] = (m_cap[0] & ~clr) | rise;
      n_cap[1] = (m_cap[1] & ~clr) | fall;
      n_cap[2] = (m_cap[2] & ~clr) | rise | fall;
      n_mask = (wr && address == 2'd2) ? writedata[15:0] : m_mask;
      n_prev = cur;
      for (int t = 0; t < 3; t++) begin
        case (address)
          2'd0:    n_rd[t] = {16'h0, cur};
          2'd2:    n_rd[t] = {16'h0, m_mask};
          2'd3:    n_rd[t] = {16'h0, m_cap[t]};
          default: n_rd[t] = 32'h0;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_hist = n_hist; m_cap = n_cap; m_rd = n_rd; m_cnt = n_cnt;
    m_deb = n_deb; m_prev = n_prev; m_mask = n_mask;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 16'hFFFF; address = 2'd3;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    repeat (3) begin
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== 32'h0 || d_irq[t] !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_state dut%0d: rd=%h irq=%b, required rd=0 irq=0", t, d_rd[t], d_irq[t]);
        end
      end
    end
    reset_n = 1'b1;
    for (int c = 1; c <= SETTLE; c++) begin
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== m_rd[t] || d_irq[t] !== m_irq(t)) begin
          n_errors++;
          $display("FAIL reset_release dut%0d c%0d: rd=%h irq=%b, required rd=%h irq=%b", t, c, d_rd[t], d_irq[t], m_rd[t], m_irq(t));
        end
      end
`ifndef NIOS_PIO_DEBOUNCE_EN
      if (c == 4) begin
        n_checks++;
        if (d_rd[0] !== 32'hFFFF || d_rd[1] !== 32'h0 || d_rd[2] !== 32'hFFFF) begin
          n_errors++;
          $display("FAIL reset_edge_capture: rd=%h/%h/%h, required 0000ffff/00000000/0000ffff", d_rd[0], d_rd[1], d_rd[2]);
        end
      end
`endif
    end
  endtask

  task automatic test_data_read();
    in_port = 16'hA5C3; address = 2'd0;
    for (int c = 1; c <= SETTLE; c++) begin
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== m_rd[t]) begin
          n_errors++;
          $display("FAIL data_read dut%0d c%0d: rd=%h, required %h", t, c, d_rd[t], m_rd[t]);
        end
      end
`ifndef NIOS_PIO_DEBOUNCE_EN
      if (c == 3) begin
        n_checks++;
        if (d_rd[0] !== 32'h0000A5C3) begin
          n_errors++;
          $display("FAIL data_latency: rd=%h, required 0000a5c3", d_rd[0]);
        end
      end
`endif
    end
    do_write(2'd0, 32'hFFFFFFFF);
    tick();
    n_checks++;
    if (d_rd[0] !== m_rd[0] || m_rd[0] !== 32'h0000A5C3) begin
      n_errors++;
      $display("FAIL data_write_ignored: rd=%h, model=%h, required 0000a5c3", d_rd[0], m_rd[0]);
    end
  endtask

  task automatic test_edge_irq();
    in_port = 16'h0000;
    settle(SETTLE);
    do_write(2'd3, 32'hFFFFFFFF);
    do_write(2'd2, 32'h1);
    address = 2'd3;
    in_port = 16'h0001;
    for (int c = 1; c <= SETTLE; c++) begin
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== m_rd[t] || d_irq[t] !== m_irq(t)) begin
          n_errors++;
          $display("FAIL edge_irq dut%0d c%0d: rd=%h irq=%b, required rd=%h irq=%b", t, c, d_rd[t], d_irq[t], m_rd[t], m_irq(t));
        end
      end
`ifndef NIOS_PIO_DEBOUNCE_EN
      if (c == 3) begin
        n_checks++;
        if (d_irq[0] !== 1'b1 || d_irq[1] !== 1'b0 || d_irq[2] !== 1'b1) begin
          n_errors++;
          $display("FAIL irq_latency: irq=%b%b%b, required 101", d_irq[0], d_irq[1], d_irq[2]);
        end
      end
`endif
    end
    address = 2'd2;
    tick();
    n_checks++;
    if (d_rd[0] !== 32'h1) begin
      n_errors++;
      $display("FAIL mask_readback: rd=%h, required 00000001", d_rd[0]);
    end
  endtask

  task automatic test_w1c_collision();
    in_port = 16'h0000;
    settle(SETTLE);
    do_write(2'd3, 32'hFFFFFFFF);
    in_port = 16'h0001;
    settle(SYNC + DEB * 0
`ifdef NIOS_PIO_DEBOUNCE_EN
      + DEB
`endif
    );
    do_write(2'd3, 32'h1);
    for (int t = 0; t < 3; t++) begin
      n_checks++;
      if (d_irq[t] !== m_irq(t)) begin
        n_errors++;
        $display("FAIL w1c_collision dut%0d: irq=%b, required %b", t, d_irq[t], m_irq(t));
      end
    end
    n_checks++;
    if (d_irq[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL w1c_set_wins: irq=%b, required 1", d_irq[0]);
    end
    do_write(2'd3, 32'h1);
    n_checks++;
    if (d_irq[0] !== 1'b0 || d_irq[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL w1c_clear: irq=%b/%b, required 0/0", d_irq[0], d_irq[2]);
    end
  endtask

  task automatic test_edge_type();
    in_port = 16'h0002;
    settle(SETTLE);
    do_write(2'd3, 32'hFFFFFFFF);
    do_write(2'd2, 32'hFFFF);
    address = 2'd3;
    in_port = 16'h0000;
    for (int c = 1; c <= SETTLE; c++) begin
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== m_rd[t] || d_irq[t] !== m_irq(t)) begin
          n_errors++;
          $display("FAIL edge_type dut%0d c%0d: rd=%h irq=%b, required rd=%h irq=%b", t, c, d_rd[t], d_irq[t], m_rd[t], m_irq(t));
        end
      end
    end
    n_checks++;
    if (d_rd[0] !== 32'h0 || d_rd[1] !== 32'h2 || d_rd[2] !== 32'h2) begin
      n_errors++;
      $display("FAIL falling_capture: rd=%h/%h/%h, required 00000000/00000002/00000002", d_rd[0], d_rd[1], d_rd[2]);
    end
  endtask

`ifdef NIOS_PIO_DEBOUNCE_EN
  task automatic test_debounce();
    in_port = 16'h0000;
    settle(SETTLE);
    do_write(2'd3, 32'hFFFFFFFF);
    do_write(2'd2, 32'hFFFF);
    address = 2'd0;
    in_port = 16'h0004;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) in_port = 16'h0000;
      n_checks++;
      if (d_rd[0] !== m_rd[0] || d_rd[0][2] !== 1'b0 || d_irq[2] !== 1'b0) begin
        n_errors++;
        $display("FAIL debounce_glitch c%0d: rd=%h irq=%b, required rd=%h irq=0", c, d_rd[0], d_irq[2], m_rd[0]);
      end
    end
    in_port = 16'h0004;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 6) in_port = 16'h0000;
      n_checks++;
      if (d_rd[0] !== m_rd[0] || d_irq[2] !== m_irq(2)) begin
        n_errors++;
        $display("FAIL debounce_pulse c%0d: rd=%h irq=%b, required rd=%h irq=%b", c, d_rd[0], d_irq[2], m_rd[0], m_irq(2));
      end
      if (c == 6 || c == 7) begin
        n_checks++;
        if (d_rd[0][2] !== (c == 7)) begin
          n_errors++;
          $display("FAIL debounce_latency c%0d: bit2=%b, required %b", c, d_rd[0][2], (c == 7));
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = 16'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      reset_n = !(c >= 300 && c < 302);
      address = 2'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom); write_n = 1'b1; writedata = $urandom;
      end
      tick();
      for (int t = 0; t < 3; t++) begin
        n_checks++;
        if (d_rd[t] !== m_rd[t] || d_irq[t] !== m_irq(t)) begin
          n_errors++;
          $display("FAIL random dut%0d c%0d: rd=%h irq=%b, required rd=%h irq=%b", t, c, d_rd[t], d_irq[t], m_rd[t], m_irq(t));
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_edge_irq();
    test_w1c_collision();
    test_edge_type();
`ifdef NIOS_PIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
